// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the multiply/divide unit.
//   op_t    : operation code presented on the unit's op port (6 and 7 are no-ops)
//   state_t : sequencer states IDLE -> CALC -> FIXUP -> IDLE
package muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP
  } state_t;

  function automatic logic is_mul(input op_t op);
    return (op == MULT) || (op == MULTU);
  endfunction

  function automatic logic is_signed(input op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

  function automatic logic is_muldiv(input op_t op);
    return is_mul(op) || (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate, used for operand magnitudes and
// result sign correction.
//   a_i   : value in
//   neg_i : 1 = negate, 0 = pass through
//   y_o   : result
module muldiv_signfix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = a_i;
    if (neg_i) y_o = ~a_i + WIDTH'(1);
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Signed/unsigned MULT and DIV take WIDTH iteration cycles plus one sign-fix
// cycle; MTHI/MTLO write HI/LO directly from IDLE.
//   clk, reset_n : clock, synchronous active-low reset
//   start, op    : launch request and operation (sampled only in IDLE)
//   kill         : abandon an in-flight MULT/DIV; also blocks a same-cycle start
//   srca, srcb   : operand A (multiplicand/dividend/MTxx data), operand B
//   busy         : high in CALC and FIXUP
//   done         : one-cycle pulse after HI/LO are written by MULT/DIV
//   hi, lo       : HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  op_t              op,
  input  logic             kill,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               mul_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic [WIDTH-1:0]   opb_q;      // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q;      // {partial product/remainder, multiplier/quotient}
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q;

  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] res_in, res_fix;
  logic [WIDTH-1:0]   rem_fix;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_t;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;

  assign a_neg  = is_signed(op) & srca[WIDTH-1];
  assign b_neg  = is_signed(op) & srcb[WIDTH-1];
  assign b_zero = (srcb == '0);

  muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (.a_i(srca), .neg_i(a_neg), .y_o(a_abs));
  muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (.a_i(srcb), .neg_i(b_neg), .y_o(b_abs));

  // Product and quotient share one 2W-wide negator; quotient is zero-extended.
  always_comb begin
    res_in = {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
    if (mul_q) res_in = acc_q;
  end

  muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_res (.a_i(res_in), .neg_i(neg_res_q), .y_o(res_fix));
  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_rem (.a_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(neg_rem_q),
                                             .y_o(rem_fix));

  // One iteration step. The divide compare uses the guard bit (div_t[WIDTH]);
  // the subtraction only needs WIDTH bits because its result is below the divisor.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, opb_q} & {(WIDTH+1){acc_q[0]}});
    div_t   = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge  = (div_t >= {1'b0, opb_q});
    div_rem = div_t[WIDTH-1:0];
    if (div_ge) div_rem = div_t[WIDTH-1:0] - opb_q;
    acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
    if (mul_q) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mul_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opb_q     <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !kill) begin
            if (op == MTHI) begin
              hi_q <= srca;
            end else if (op == MTLO) begin
              lo_q <= srca;
            end else if (is_muldiv(op)) begin
              mul_q   <= is_mul(op);
              cnt_q   <= CNT_W'(WIDTH);
              busy_q  <= 1'b1;
              state_q <= CALC;
              if (is_mul(op)) begin
                acc_q     <= {{WIDTH{1'b0}}, b_abs};
                opb_q     <= a_abs;
                neg_res_q <= a_neg ^ b_neg;
                neg_rem_q <= 1'b0;
              end else begin
                acc_q     <= {{WIDTH{1'b0}}, a_abs};
                opb_q     <= b_abs;
                // divide by zero keeps the raw all-ones quotient
                neg_res_q <= (a_neg ^ b_neg) & ~b_zero;
                neg_rem_q <= a_neg;
              end
            end
          end
        end
        CALC: begin
          if (kill) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_q <= FIXUP;
          end
        end
        FIXUP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!kill) begin
            done_q <= 1'b1;
            lo_q   <= res_fix[WIDTH-1:0];
            if (mul_q) hi_q <= res_fix[2*WIDTH-1:WIDTH];
            else       hi_q <= rem_fix;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic        rst32_n, start32, kill32, busy32, done32;
  op_t         op32;
  logic [31:0] a32, b32, hi32, lo32;

  logic        rst8_n, start8, kill8, busy8, done8;
  op_t         op8;
  logic [7:0]  a8, b8, hi8, lo8;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset_n(rst32_n), .start(start32), .op(op32), .kill(kill32),
    .srca(a32), .srcb(b32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(rst8_n), .start(start8), .op(op8), .kill(kill8),
    .srca(a8), .srcb(b8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned sc;   // cycle count right after the start edge
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitors: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done32) begin
      if (q32.size() == 0) begin
        chk("done32_unexpected", {31'b0, done32}, 32'd0);
      end else begin
        e32 = q32.pop_front();
        chk("hi32", hi32, e32.hi);
        chk("lo32", lo32, e32.lo);
        chk("latency32", cyc - e32.sc + 1, 32'd34);
      end
    end
  end

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        chk("done8_unexpected", {31'b0, done8}, 32'd0);
      end else begin
        e8 = q8.pop_front();
        chk("hi8", {24'b0, hi8}, e8.hi);
        chk("lo8", {24'b0, lo8}, e8.lo);
        chk("latency8", cyc - e8.sc + 1, 32'd10);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue32(input op_t o, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] eh, input logic [31:0] el);
    @(negedge clk);
    start32 = 1'b1; op32 = o; a32 = a; b32 = b;
    @(posedge clk); #1;
    if (push) q32.push_back('{eh, el, cyc});
    @(negedge clk);
    start32 = 1'b0;
  endtask

  task automatic issue8(input op_t o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eh, input logic [7:0] el);
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = a; b8 = b;
    @(posedge clk); #1;
    q8.push_back('{{24'b0, eh}, {24'b0, el}, cyc});
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q32.size() + q8.size(), 32'd0);
    q32.delete();
    q8.delete();
    @(negedge clk);
  endtask

  task automatic run32(input op_t o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
    issue32(o, a, b, 1'b1, eh, el);
    drain(100);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst32_n = 1'b0; start32 = 1'b0; kill32 = 1'b0; op32 = MULT; a32 = '0; b32 = '0;
    rst8_n  = 1'b0; start8  = 1'b0; kill8  = 1'b0; op8  = MULT; a8  = '0; b8  = '0;
    idle(3);
    chk("rst_busy32", {31'b0, busy32}, 32'd0);
    chk("rst_done32", {31'b0, done32}, 32'd0);
    chk("rst_hi32", hi32, 32'd0);
    chk("rst_lo32", lo32, 32'd0);
    chk("rst_busy8", {31'b0, busy8}, 32'd0);
    chk("rst_hi8", {24'b0, hi8}, 32'd0);
    chk("rst_lo8", {24'b0, lo8}, 32'd0);
    rst32_n = 1'b1;
    rst8_n  = 1'b1;
    idle(1);

    // Directed arithmetic vectors
    run32(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run32(MULT,  32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run32(DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run32(DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF);
    run32(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run32(DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run32(DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF);
    run32(MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

    // Back-to-back: new start in the cycle done is high
    issue32(DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
    n = 0;
    while (!done32 && n < 60) begin
      @(negedge clk);
      n++;
    end
    start32 = 1'b1; op32 = MULTU; a32 = 32'd6; b32 = 32'd7;
    @(posedge clk); #1;
    q32.push_back('{32'd0, 32'd42, cyc});
    @(negedge clk);
    start32 = 1'b0;
    drain(100);

    // Starts while busy are ignored
    issue32(DIVU, 32'd10, 32'd3, 1'b1, 32'd1, 32'd3);
    idle(3);
    issue32(MTHI, 32'h55, 32'd0, 1'b0, 32'd0, 32'd0);
    chk("busy_mthi_ignored", hi32, 32'd0);
    chk("busy_during_calc", {31'b0, busy32}, 32'd1);
    idle(3);
    issue32(DIVU, 32'd200, 32'd7, 1'b0, 32'd0, 32'd0);
    drain(100);
    idle(40);

    // MTHI/MTLO, then kill mid-CALC
    issue32(MTHI, 32'h1234, 32'd0, 1'b0, 32'd0, 32'd0);
    chk("mthi_hi", hi32, 32'h1234);
    chk("mthi_busy", {31'b0, busy32}, 32'd0);
    issue32(MTLO, 32'h5678, 32'd0, 1'b0, 32'd0, 32'd0);
    chk("mtlo_lo", lo32, 32'h5678);
    issue32(MULT, 32'h11, 32'h22, 1'b0, 32'd0, 32'd0);
    idle(8);
    chk("prekill_busy", {31'b0, busy32}, 32'd1);
    kill32 = 1'b1;
    @(posedge clk); #1;
    chk("kill_busy", {31'b0, busy32}, 32'd0);
    chk("kill_done", {31'b0, done32}, 32'd0);
    chk("kill_hi", hi32, 32'h1234);
    chk("kill_lo", lo32, 32'h5678);
    @(negedge clk);

    // kill in IDLE blocks a same-cycle start
    issue32(MTHI, 32'h99, 32'd0, 1'b0, 32'd0, 32'd0);
    chk("idle_kill_mthi", hi32, 32'h1234);
    issue32(MULTU, 32'd2, 32'd2, 1'b0, 32'd0, 32'd0);
    chk("idle_kill_busy", {31'b0, busy32}, 32'd0);
    kill32 = 1'b0;
    idle(40);

    // Reset during CALC discards the op
    issue32(MULTU, 32'd3, 32'd5, 1'b0, 32'd0, 32'd0);
    idle(5);
    rst32_n = 1'b0;
    @(posedge clk); #1;
    chk("rstcalc_busy", {31'b0, busy32}, 32'd0);
    chk("rstcalc_done", {31'b0, done32}, 32'd0);
    chk("rstcalc_hi", hi32, 32'd0);
    chk("rstcalc_lo", lo32, 32'd0);
    @(negedge clk);
    rst32_n = 1'b1;
    idle(40);
    run32(MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

    // WIDTH=8 instance
    issue8(MULTU, 8'hFF, 8'hFF, 8'hFE, 8'h01);
    drain(40);
    issue8(DIV, 8'h80, 8'hFF, 8'h00, 8'h80);
    drain(40);
    issue8(DIV, 8'hF9, 8'h02, 8'hFF, 8'hFD);
    drain(40);
    issue8(DIVU, 8'd100, 8'd0, 8'h64, 8'hFF);
    drain(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Successor to the current unsigned-only divider plus special-register pair.
- Adds signed and unsigned MULT/DIV, MTHI/MTLO, a start/busy/done handshake, abort, and a defined divide-by-zero result.
- Sits beside the ALU in the datapath. Operands come from regfile ports srca/writedata. HI/LO feed the mfhi/mflo result mux.

Parameters:
- WIDTH, 32, operand and HI/LO width (≥4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, do not override).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous reset, active low
- start  in  1  launch op; sampled only in IDLE
- op  in  3  muldiv_pkg::op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO
- kill  in  1  abort in-flight op (pipeline flush)
- srca  in  WIDTH  operand A (multiplicand/dividend/MTxx data)
- srcb  in  WIDTH  operand B (multiplier/divisor)
- busy  out  1  high in CALC and FIXUP
- done  out  1  one-cycle pulse when HI/LO updated by MULT/DIV
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (reset_n=0 at clk edge): state=IDLE, hi=lo=0, busy=0, done=0, counter=0. Overrides start/kill; an op in flight is discarded.
- States: IDLE → CALC → FIXUP → IDLE.
- IDLE, start=1, op MTHI/MTLO: hi (or lo) ← srca at that edge. Stays IDLE; no busy, no done.
- IDLE, start=1, op MULT*/DIV*: latch |srca| and |srcb| (signed ops) or raw values (unsigned ops). Latch result-sign flags. Load counter=WIDTH. Go to CALC.
- CALC, multiply: shift-add, 1 multiplier bit/cycle, 2·WIDTH-bit accumulator.
- CALC, divide: restoring, 1 quotient bit/cycle, WIDTH-bit partial remainder plus 1 guard bit.
- CALC: counter decrements each cycle. When counter reaches 1, go to FIXUP next. CALC lasts exactly WIDTH cycles.
- FIXUP, sign correction:
  - Product negated if signs differ (signed MULT).
  - Quotient negated if signs differ.
  - Remainder takes the dividend's sign.
- FIXUP, write: hi/lo written at the FIXUP→IDLE edge.
  - MULT: hi=product[2W-1:W], lo=product[W-1:0].
  - DIV: lo=quotient, hi=remainder.
- done=1 for the cycle after that edge (state IDLE).
- Latency: start edge to done high = WIDTH+2 cycles (34 at default). busy is high WIDTH+1 cycles.
- Back-to-back: a new start is accepted in the same cycle done is high.
- start while busy: ignored, no queueing. Control must hold/stall.
- Divide by zero (srcb=0, DIV or DIVU): lo=all ones, hi=srca. Same latency, done pulses.
- Signed overflow (DIV, srca=most-negative, srcb=-1): lo=most-negative, hi=0.
- kill=1 in CALC/FIXUP: return to IDLE next edge. hi/lo unchanged, no done. kill in IDLE: no effect, and it blocks a same-cycle start.
- kill and reset together: reset wins.
- hi/lo are stable and readable in every state; new values appear only after the FIXUP edge.

Decomposition:
- muldiv_pkg:
  - op_t enum (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6,7 treated as no-op).
  - state_t enum (IDLE, CALC, FIXUP).
  - Helper functions is_mul(op), is_signed(op).
- Sub-module muldiv_signfix, purely combinational, parametrised WIDTH:
  - Input abs: conditional two's-complement negate.
  - Output correction: same negate, instantiated twice.
- FSM, counter, and iteration datapath stay in muldiv_unit.

Test Plan:
- MULTU 0xFFFFFFFF×0xFFFFFFFF → done at cycle 34, hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFF9(-7)×3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/0 → lo=0xFFFFFFFF, hi=0x00000064, done pulses. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Start DIVU 10/3, then MTHI 0x55 at cycle 5 and DIVU again at cycle 10: both ignored. Final lo=3, hi=1; one done.
- MTHI 0x1234, then MTLO 0x5678, then kill at CALC cycle 10 of a MULT → hi=0x1234, lo=0x5678, no done, busy low next cycle.
- reset_n=0 during CALC → next cycle busy=0, hi=lo=0, done=0. Re-run with WIDTH=8: MULTU 0xFF×0xFF → hi=0xFE, lo=0x01, latency 10.
